// File: rtl/key_pkg.sv
// Shared defaults and state encoding for the key loader and any locked-netlist
// benches that reuse the checksum fold.
package key_pkg;

    localparam int KEY_W_DEF = 12;
    localparam int CHK_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } key_state_t;

    // Bit counter must hold KEY_W+CHK_W without wrapping inside a frame.
    function automatic int cnt_width(input int key_w, input int chk_w);
        return $clog2(key_w + chk_w + 1);
    endfunction

endpackage

// File: rtl/key_chk_fold.sv
// Folds a key into CHK_W bits by XOR-ing consecutive CHK_W-bit chunks,
// chunk 0 taken from the key LSBs.
module key_chk_fold
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic [KEY_W-1:0] key,
    output logic [CHK_W-1:0] chk
);

    localparam int N_CHUNKS = KEY_W / CHK_W;

    always_comb begin
        chk = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            chk = chk ^ key[i*CHK_W +: CHK_W];
        end
    end

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts in a key plus checksum frame, verifies the fold,
// and only then exposes the key to the lock-select inputs.
module key_loader
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             load_err,
    output logic             busy
);

    localparam int CNT_W = cnt_width(KEY_W, CHK_W);
    localparam logic [CNT_W-1:0] KEY_BITS = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W + CHK_W - 1);

    key_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [KEY_W-1:0] shift_key;
    logic [CHK_W-1:0] shift_chk;
    logic [CHK_W-1:0] fold_chk;
    logic             chk_match;

    key_chk_fold #(
        .KEY_W(KEY_W),
        .CHK_W(CHK_W)
    ) u_fold (
        .key(shift_key),
        .chk(fold_chk)
    );

    assign chk_match = (fold_chk == shift_chk);

    // The received key lives only in shift_key until CHECK passes, so key never
    // shows a partial value. busy/sin_ready are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_key <= '0;
            shift_chk <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
            sin_ready <= 1'b0;
        end else if (zeroize) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_key <= '0;
            shift_chk <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
            sin_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RECV;
                        bit_cnt   <= '0;
                        shift_key <= '0;
                        shift_chk <= '0;
                        key       <= '0;
                        key_valid <= 1'b0;
                        load_err  <= 1'b0;
                        busy      <= 1'b1;
                        sin_ready <= 1'b1;
                    end
                end
                RECV: begin
                    if (sin_valid) begin
                        if (bit_cnt < KEY_BITS) begin
                            shift_key <= {sin_data, shift_key[KEY_W-1:1]};
                        end else begin
                            shift_chk <= {sin_data, shift_chk[CHK_W-1:1]};
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= CHECK;
                            sin_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (chk_match) begin
                        key       <= shift_key;
                        key_valid <= 1'b1;
                    end else begin
                        load_err  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sin_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good/bad checksum loads, gapped input,
// zeroize, restart, reset abort and start/zeroize collision.
module tb_key_loader;

    localparam int KEY_W = 12;
    localparam int CHK_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             zeroize;
    logic             sin_valid;
    logic             sin_data;
    logic             sin_ready;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             load_err;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted;

    key_loader #(
        .KEY_W(KEY_W),
        .CHK_W(CHK_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .zeroize(zeroize),
        .sin_valid(sin_valid),
        .sin_data(sin_data),
        .sin_ready(sin_ready),
        .key(key),
        .key_valid(key_valid),
        .load_err(load_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends a full frame {c,k} LSB first; gaps toggles sin_valid 1-0-1-0,
    // stray_start pulses start mid-frame. Returns on the cycle after the last handshake.
    task automatic applyStimulus(input logic [11:0] k, input logic [3:0] c, input bit gaps,
                                 input bit stray_start, output int n_acc);
        logic [15:0] frame;
        int idx;
        int budget;
        bit phase;
        frame  = {c, k};
        idx    = 0;
        budget = 0;
        phase  = 1'b1;
        n_acc  = 0;
        while (idx < 16 && budget < 200) begin
            sin_valid = gaps ? phase : 1'b1;
            sin_data  = frame[idx];
            start     = (stray_start && idx == 5) ? 1'b1 : 1'b0;
            if (sin_valid && sin_ready) begin
                idx++;
                n_acc++;
            end
            tick();
            phase = ~phase;
            budget++;
        end
        sin_valid = 1'b0;
        start     = 1'b0;
        if (idx < 16) checkOutput("frame_timeout", idx, 16);
    endtask

    task automatic sendPartial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sin_valid = 1'b1;
            sin_data  = i[0];
            tick();
        end
        sin_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; zeroize = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
        tick(); tick();
        checkOutput("rst_key", key, 0);
        checkOutput("rst_key_valid", key_valid, 0);
        checkOutput("rst_load_err", load_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sin_ready", sin_ready, 0);
        rst = 1'b0;
        tick();

        // Good load, sin_valid held high
        pulseStart();
        checkOutput("recv_busy", busy, 1);
        checkOutput("recv_ready", sin_ready, 1);
        applyStimulus(12'hA5C, 4'h3, 1'b0, 1'b0, accepted);
        checkOutput("check_busy", busy, 1);
        checkOutput("check_ready", sin_ready, 0);
        checkOutput("check_no_early_valid", key_valid, 0);
        tick();
        checkOutput("good_key_valid", key_valid, 1);
        checkOutput("good_key", key, 12'hA5C);
        checkOutput("good_load_err", load_err, 0);
        checkOutput("good_idle_busy", busy, 0);

        // Bad checksum
        pulseStart();
        checkOutput("restart_key_cleared", key, 0);
        checkOutput("restart_valid_cleared", key_valid, 0);
        applyStimulus(12'hA5C, 4'h4, 1'b0, 1'b0, accepted);
        tick();
        checkOutput("bad_load_err", load_err, 1);
        checkOutput("bad_key_valid", key_valid, 0);
        checkOutput("bad_key", key, 0);

        // Gapped load, extra valid bits afterwards must be ignored
        pulseStart();
        checkOutput("restart_err_cleared", load_err, 0);
        applyStimulus(12'hA5C, 4'h3, 1'b1, 1'b0, accepted);
        checkOutput("gap_accepted", accepted, 16);
        sin_valid = 1'b1; sin_data = 1'b1;
        tick();
        checkOutput("gap_key_valid", key_valid, 1);
        checkOutput("gap_key", key, 12'hA5C);
        tick(); tick();
        sin_valid = 1'b0;
        checkOutput("idle_ignores_valid", key, 12'hA5C);
        checkOutput("idle_ready", sin_ready, 0);

        // Restart after success, second key with stray start mid-frame
        pulseStart();
        checkOutput("second_start_key", key, 0);
        checkOutput("second_start_valid", key_valid, 0);
        applyStimulus(12'h0F0, 4'hF, 1'b0, 1'b1, accepted);
        tick();
        checkOutput("second_key_valid", key_valid, 1);
        checkOutput("second_key", key, 12'h0F0);

        // Zeroize after 7 accepted bits
        pulseStart();
        sendPartial(7);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_ready", sin_ready, 0);
        checkOutput("zero_key", key, 0);
        checkOutput("zero_valid", key_valid, 0);
        // Counter must restart from 0 after zeroize
        pulseStart();
        applyStimulus(12'h123, 4'h0, 1'b0, 1'b0, accepted);
        tick();
        checkOutput("post_zero_key", key, 12'h123);
        checkOutput("post_zero_valid", key_valid, 1);

        // Zeroize in IDLE clears a committed key
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checkOutput("idle_zero_key", key, 0);

        // Start and zeroize together: zeroize wins
        start = 1'b1; zeroize = 1'b1;
        tick();
        start = 1'b0; zeroize = 1'b0;
        checkOutput("collide_ready", sin_ready, 0);
        checkOutput("collide_busy", busy, 0);
        tick();
        checkOutput("collide_ready_later", sin_ready, 0);

        // Reset mid-frame aborts without commit, and beats start
        pulseStart();
        sendPartial(10);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_abort_busy", busy, 0);
        checkOutput("rst_abort_ready", sin_ready, 0);
        checkOutput("rst_abort_key", key, 0);
        tick();
        checkOutput("rst_abort_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
